// File: rtl/vid_src_pkg.sv
// Shared encodings for the test-pattern source: pattern selects, bar colours, FSM states.
package vid_src_pkg;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_RAMP  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_SOLID = 2'd3;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vid_state_t;

    typedef struct packed {
        logic de;
        logic h_sync;
        logic v_sync;
        logic frame_start;
    } vid_ctl_t;

    // Bar colour for bar index 0 (left) .. 7 (right).
    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vid_timing.sv
// Raster counters, IDLE/RUN control and unregistered de/sync/frame_start decode.
// VID_SRC_FRAME_CNT_EN adds a free-running frame counter.
module vid_timing
    import vid_src_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_ACT = 1'b1,
    localparam int unsigned HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int unsigned VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [HW-1:0] o_h_cnt,
    output logic [VW-1:0] o_v_cnt,
    output logic          o_h_act_c,
    output vid_ctl_t      o_ctl_c
`ifdef VID_SRC_FRAME_CNT_EN
    ,
    output logic [15:0]   o_frame_cnt
`endif
);

    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS_C   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE_C   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST_C = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS_C   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE_C   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST_C = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    vid_state_t    r_state, w_state_nxt;
    logic [HW-1:0] r_h_cnt, w_h_nxt;
    logic [VW-1:0] r_v_cnt, w_v_nxt;
    logic          w_run, w_h_last, w_v_last;

    assign w_run    = (r_state == ST_RUN);
    assign w_h_last = (r_h_cnt == H_LAST_C);
    assign w_v_last = (r_v_cnt == V_LAST_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_h_cnt <= w_h_nxt;
            r_v_cnt <= w_v_nxt;
        end
    end

    // Leaving RUN is only allowed on the last pixel so a frame is never cut short.
    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h_cnt;
        w_v_nxt     = r_v_cnt;
        case (r_state)
            ST_IDLE: begin
                w_h_nxt = '0;
                w_v_nxt = '0;
                if (en) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_h_last) begin
                    w_h_nxt = '0;
                    if (w_v_last) begin
                        w_v_nxt = '0;
                        if (!en) w_state_nxt = ST_IDLE;
                    end else begin
                        w_v_nxt = r_v_cnt + VW'(1);
                    end
                end else begin
                    w_h_nxt = r_h_cnt + HW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ctl_c             = '0;
        o_ctl_c.de          = w_run && (r_h_cnt < H_ACT_C) && (r_v_cnt < V_ACT_C);
        o_ctl_c.h_sync      = (w_run && (r_h_cnt >= H_SS_C) && (r_h_cnt < H_SE_C)) ? SYNC_ACT : ~SYNC_ACT;
        o_ctl_c.v_sync      = (w_run && (r_v_cnt >= V_SS_C) && (r_v_cnt < V_SE_C)) ? SYNC_ACT : ~SYNC_ACT;
        o_ctl_c.frame_start = w_run && (r_h_cnt == '0) && (r_v_cnt == '0);
    end

    assign o_h_cnt   = r_h_cnt;
    assign o_v_cnt   = r_v_cnt;
    assign o_h_act_c = w_run && (r_h_cnt < H_ACT_C);

`ifdef VID_SRC_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_run && w_h_last && w_v_last) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign o_frame_cnt = r_frame_cnt;
`endif

endmodule

// File: rtl/vid_src.sv
// Video timing generator with test patterns (bars, ramp, checkerboard, solid).
// VID_SRC_FRAME_CNT_EN adds frame_cnt and makes the checkerboard scroll.
module vid_src
    import vid_src_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_ACT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_rgb,
    output logic        de_out,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic [23:0] pixel_out,
    output logic        frame_start
`ifdef VID_SRC_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int unsigned HW    = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int unsigned VW    = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int unsigned BAR_W = H_ACTIVE / 8;
    localparam int unsigned BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [HW-1:0] w_h_cnt;
    logic [VW-1:0] w_v_cnt;
    logic          w_h_act;
    vid_ctl_t      w_ctl;
    logic [15:0]   w_chk_h;
    logic          w_chk;
    logic [7:0]    w_ramp;
    logic [1:0]    w_pat, r_pat;
    logic [23:0]   w_solid, r_solid;
    logic [23:0]   w_pix;
    logic [BW-1:0] r_bar_px;
    logic [2:0]    r_bar_idx;

    vid_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_ACT (SYNC_ACT)
    ) u_timing (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .o_h_cnt   (w_h_cnt),
        .o_v_cnt   (w_v_cnt),
        .o_h_act_c (w_h_act),
        .o_ctl_c   (w_ctl)
`ifdef VID_SRC_FRAME_CNT_EN
        ,
        .o_frame_cnt (frame_cnt)
`endif
    );

    // New selections take effect on the first pixel of a frame and hold until the next.
    assign w_pat   = w_ctl.frame_start ? pattern_sel : r_pat;
    assign w_solid = w_ctl.frame_start ? solid_rgb   : r_solid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat   <= PAT_BARS;
            r_solid <= '0;
        end else begin
            r_pat   <= w_pat;
            r_solid <= w_solid;
        end
    end

    // Bar index tracks h_cnt / BAR_W by counting pixels within the current bar.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bar_px  <= '0;
            r_bar_idx <= '0;
        end else if (!w_h_act) begin
            r_bar_px  <= '0;
            r_bar_idx <= '0;
        end else if (r_bar_px == BW'(BAR_W - 1)) begin
            r_bar_px  <= '0;
            r_bar_idx <= r_bar_idx + 3'd1;
        end else begin
            r_bar_px  <= r_bar_px + BW'(1);
        end
    end

`ifdef VID_SRC_FRAME_CNT_EN
    assign w_chk_h = 16'(w_h_cnt) + frame_cnt;
`else
    assign w_chk_h = 16'(w_h_cnt);
`endif
    assign w_chk  = (|(w_chk_h & 16'h0008)) ^ (|(16'(w_v_cnt) & 16'h0008));
    assign w_ramp = 8'(w_h_cnt);

    always_comb begin
        w_pix = '0;
        if (w_ctl.de) begin
            case (w_pat)
                PAT_BARS:  w_pix = bar_rgb(r_bar_idx);
                PAT_RAMP:  w_pix = {3{w_ramp}};
                PAT_CHECK: w_pix = w_chk ? 24'hFFFFFF : 24'h000000;
                PAT_SOLID: w_pix = w_solid;
                default:   w_pix = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_out      <= 1'b0;
            h_sync_out  <= ~SYNC_ACT;
            v_sync_out  <= ~SYNC_ACT;
            pixel_out   <= '0;
            frame_start <= 1'b0;
        end else begin
            de_out      <= w_ctl.de;
            h_sync_out  <= w_ctl.h_sync;
            v_sync_out  <= w_ctl.v_sync;
            pixel_out   <= w_pix;
            frame_start <= w_ctl.frame_start;
        end
    end

endmodule

// File: tb/tb_vid_src.sv
// Directed scoreboard bench for vid_src on a 16/2/2/2 x 4/1/1/1 raster.
module tb_vid_src;

    localparam int H_TOT = 22;
    localparam int V_TOT = 7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  pattern_sel;
    logic [23:0] solid_rgb;
    logic        de_out;
    logic        h_sync_out;
    logic        v_sync_out;
    logic [23:0] pixel_out;
    logic        frame_start;

    vid_src #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4),  .V_FP (1), .V_SYNC (1), .V_BP (1),
        .SYNC_ACT (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .pattern_sel (pattern_sel),
        .solid_rgb   (solid_rgb),
        .de_out      (de_out),
        .h_sync_out  (h_sync_out),
        .v_sync_out  (v_sync_out),
        .pixel_out   (pixel_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [23:0] px;
    } obs_t;

    obs_t exp_q[$];
    int   errors    = 0;
    int   checks    = 0;
    int   sample_no = 0;
    int   last_fs   = -1;
    int   fs_period = 0;
    int   de_seen   = 0;
    int   fs_seen   = 0;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_de"}, 24'(de_out), 24'h0);
        check({tag, "_hs"}, 24'(h_sync_out), 24'h0);
        check({tag, "_vs"}, 24'(v_sync_out), 24'h0);
        check({tag, "_px"}, pixel_out, 24'h0);
        check({tag, "_fs"}, 24'(frame_start), 24'h0);
    endtask

    function automatic logic [23:0] bar_exp(input int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic obs_t exp_at(input int h, input int v, input logic [1:0] pat, input logic [23:0] solid);
        obs_t e;
        e.de = (h < 16) && (v < 4);
        e.hs = (h >= 18) && (h < 20);
        e.vs = (v == 5);
        e.fs = (h == 0) && (v == 0);
        e.px = 24'h0;
        if (e.de) begin
            case (pat)
                2'd0: e.px = bar_exp(h / 2);
                2'd1: e.px = {3{8'(h)}};
                2'd2: e.px = ((((h >> 3) & 1) ^ ((v >> 3) & 1)) != 0) ? 24'hFFFFFF : 24'h000000;
                default: e.px = solid;
            endcase
        end
        return e;
    endfunction

    task automatic push_frame(input logic [1:0] pat, input logic [23:0] solid);
        for (int v = 0; v < V_TOT; v++)
            for (int h = 0; h < H_TOT; h++)
                exp_q.push_back(exp_at(h, v, pat, solid));
    endtask

    task automatic push_idle(input int n);
        obs_t e = '0;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    // Pops one expected tuple per clock and compares it with the sampled outputs.
    task automatic drain(input int n);
        obs_t got;
        obs_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_no++;
            got = {de_out, h_sync_out, v_sync_out, frame_start, pixel_out};
            if (got.de) de_seen++;
            if (got.fs) begin
                fs_seen++;
                if (last_fs >= 0) fs_period = sample_no - last_fs;
                last_fs = sample_no;
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL stream_underflow sample=%0d observed=%h", sample_no, got);
            end else begin
                e = exp_q.pop_front();
                assert (got === e) else begin
                    errors++;
                    $error("FAIL stream sample=%0d observed=%h expected=%h", sample_no, got, e);
                end
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        en          = 1'b0;
        pattern_sel = 2'd0;
        solid_rgb   = 24'h0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");

        rst_n = 1'b1;
        push_idle(3);
        drain(3);

        // Start: one idle sample while the FSM enters RUN, then pixel (0,0).
        en = 1'b1;
        push_idle(1);
        push_frame(2'd0, 24'h0);
        de_seen = 0;
        fs_seen = 0;
        drain(2);
        check("first_de", 24'(de_out), 24'h1);
        check("first_fs", 24'(frame_start), 24'h1);
        drain(153);
        check("de_per_frame", 24'(de_seen), 24'd64);
        check("fs_per_frame", 24'(fs_seen), 24'd1);

        // Solid colour latched at frame start; mid-frame change waits a frame.
        pattern_sel = 2'd3;
        solid_rgb   = 24'h123456;
        push_frame(2'd3, 24'h123456);
        drain(30);
        solid_rgb = 24'hABCDEF;
        drain(124);
        check("frame_period", 24'(fs_period), 24'd154);

        push_frame(2'd3, 24'hABCDEF);
        drain(60);
        pattern_sel = 2'd1;
        drain(94);

        push_frame(2'd1, 24'h0);
        drain(50);
        pattern_sel = 2'd2;
        drain(104);

        // en dropped at line 2: frame completes, then idle.
        push_frame(2'd2, 24'h0);
        drain(44);
        en = 1'b0;
        drain(110);
        push_idle(10);
        drain(10);
        check("queue_drained", 24'(exp_q.size()), 24'd0);

        en          = 1'b1;
        pattern_sel = 2'd0;
        push_idle(1);
        push_frame(2'd0, 24'h0);
        drain(40);

        // Asynchronous reset mid-line.
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_reset");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("reset_held");

        rst_n = 1'b1;
        push_idle(1);
        push_frame(2'd0, 24'h0);
        de_seen = 0;
        fs_seen = 0;
        drain(155);
        check("restart_de_per_frame", 24'(de_seen), 24'd64);
        check("restart_fs_per_frame", 24'(fs_seen), 24'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
